// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 bus controller
// Purpose: FSM state enum, LCD register bit positions, status bit indices,
//          power-up init command ROM and small helper functions.
// Ports:   none (package)
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } lcd_state_e;

  // Bit positions inside the memory-mapped LCD register image
  localparam int LCD_ON  = 31;
  localparam int LCD_REQ = 30;
  localparam int LCD_RS  = 9;

  // Status word bit indices
  localparam int STAT_BUSY    = 0;
  localparam int STAT_OVERRUN = 1;

  // Power-up init: 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [2:0]      INIT_LEN = 3'd4;
  localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execution
  // wait. Command layout is {RS, DATA[7:0]}.
  function automatic logic is_slow_cmd(input logic [8:0] cmd);
    return !cmd[8] && (cmd[7:2] == 6'd0) && (cmd[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - loadable down-counter with a done flag
// Purpose: one timer shared by every timed controller state. Loading N-1
//          makes done assert in the N-th cycle after the load.
// Ports:   clk      in  system clock
//          load     in  load load_val this cycle (also used as reset by owner)
//          load_val in  W-bit start value
//          done     out counter has reached zero
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/lcd_bus_ctrl.sv
// rtl/lcd_bus_ctrl.sv - HD44780 8-bit write-cycle sequencer behind the LCD register
// Purpose: detects REQ toggles in the LCD register image, captures {RS, DATA},
//          runs power-up init, then turns each command into a timed
//          setup / EN pulse / hold / execution-wait cycle. One-deep pending
//          buffer with sticky overrun. Status word = {30'b0, overrun, busy}.
// Ports:   i_clk, i_reset (sync, active-high)
//          i_io_lcd[31:0]  register image: [31] ON, [30] REQ, [9] RS, [7:0] DATA
//          o_lcd_data[7:0], o_lcd_rs, o_lcd_rw (always 0), o_lcd_en
//          o_lcd_on        registered copy of ON
//          o_lcd_status    {30'b0, overrun, busy}
module lcd_bus_ctrl
  import lcd_pkg::*;
#(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_AS_CYC    = 2,
  parameter int T_PW_CYC    = 12,
  parameter int T_H_CYC     = 2,
  parameter int T_EXEC_CYC  = 1850,
  parameter int T_CLR_CYC   = 76000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_lcd_status
);

  localparam int T_MAX = max_int(max_int(max_int(T_PWRUP_CYC, T_AS_CYC),
                                         max_int(T_PW_CYC, T_H_CYC)),
                                 max_int(T_EXEC_CYC, T_CLR_CYC));
  localparam int TW = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP_CYC - 1);
  localparam logic [TW-1:0] LD_AS    = TW'(T_AS_CYC - 1);
  localparam logic [TW-1:0] LD_PW    = TW'(T_PW_CYC - 1);
  localparam logic [TW-1:0] LD_H     = TW'(T_H_CYC - 1);
  localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC_CYC - 1);
  localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR_CYC - 1);

  lcd_state_e    state, state_n, t_sel;
  logic          pend_valid, pend_valid_n;
  logic [8:0]    pend_cmd, pend_cmd_n;
  logic [8:0]    cur_cmd;
  logic          launch;
  logic [8:0]    launch_cmd;
  logic [2:0]    init_idx, init_idx_n;
  logic          overrun, overrun_n;
  logic          req_prev;
  logic          new_req, req_taken, drop;
  logic [8:0]    new_cmd;
  logic          en_q, on_q;
  logic [31:0]   status_q, status_n;
  logic          t_load, t_done;
  logic [TW-1:0] t_val;
  logic          unused_bits;

  assign new_req     = i_io_lcd[LCD_REQ] != req_prev;
  assign new_cmd     = {i_io_lcd[LCD_RS], i_io_lcd[7:0]};
  assign unused_bits = ^{i_io_lcd[29:10], i_io_lcd[8]};

  always_comb begin
    state_n      = state;
    pend_valid_n = pend_valid;
    pend_cmd_n   = pend_cmd;
    launch       = 1'b0;
    launch_cmd   = pend_cmd;
    init_idx_n   = init_idx;
    req_taken    = 1'b0;
    drop         = 1'b0;

    case (state)
      S_PWRUP: if (t_done) state_n = S_INIT;
      S_INIT: begin
        launch     = 1'b1;
        launch_cmd = {1'b0, INIT_ROM[init_idx[1:0]]};
        init_idx_n = init_idx + 3'd1;
        state_n    = S_SETUP;
      end
      S_IDLE: begin
        if (new_req && !pend_valid) begin
          launch     = 1'b1;
          launch_cmd = new_cmd;
          req_taken  = 1'b1;
          state_n    = S_SETUP;
        end
      end
      S_SETUP: if (t_done) state_n = S_PULSE;
      S_PULSE: if (t_done) state_n = S_HOLD;
      S_HOLD:  if (t_done) state_n = S_WAIT;
      S_WAIT: begin
        if (t_done) begin
          if (init_idx < INIT_LEN) begin
            state_n = S_INIT;
          end else if (pend_valid) begin
            launch       = 1'b1;
            launch_cmd   = pend_cmd;
            pend_valid_n = 1'b0;
            state_n      = S_SETUP;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_PWRUP;
    endcase

    // Evaluated after the FSM so a slot freed by a same-cycle pending launch
    // is immediately reusable by the incoming command.
    if (new_req && !req_taken) begin
      if (!pend_valid_n) begin
        pend_valid_n = 1'b1;
        pend_cmd_n   = new_cmd;
      end else begin
        drop = 1'b1;
      end
    end

    overrun_n = i_io_lcd[LCD_ON] ? (overrun | drop) : 1'b0;

    status_n               = '0;
    status_n[STAT_BUSY]    = (state_n != S_IDLE) | pend_valid_n;
    status_n[STAT_OVERRUN] = overrun_n;
  end

  // Timer reloads on every state change; reset loads the power-up wait.
  always_comb begin
    t_load = i_reset || (state_n != state);
    t_sel  = i_reset ? S_PWRUP : state_n;
    case (t_sel)
      S_PWRUP: t_val = LD_PWRUP;
      S_SETUP: t_val = LD_AS;
      S_PULSE: t_val = LD_PW;
      S_HOLD:  t_val = LD_H;
      S_WAIT:  t_val = is_slow_cmd(cur_cmd) ? LD_CLR : LD_EXEC;
      default: t_val = '0;
    endcase
  end

  lcd_delay_timer #(.W(TW)) u_timer (
    .clk      (i_clk),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_PWRUP;
      pend_valid <= 1'b0;
      pend_cmd   <= '0;
      overrun    <= 1'b0;
      req_prev   <= 1'b0;
      init_idx   <= '0;
      cur_cmd    <= '0;
      en_q       <= 1'b0;
      on_q       <= 1'b0;
      status_q   <= '0;
    end else begin
      state      <= state_n;
      pend_valid <= pend_valid_n;
      pend_cmd   <= pend_cmd_n;
      overrun    <= overrun_n;
      req_prev   <= i_io_lcd[LCD_REQ];
      init_idx   <= init_idx_n;
      if (launch) cur_cmd <= launch_cmd;
      en_q       <= (state_n == S_PULSE);
      on_q       <= i_io_lcd[LCD_ON];
      status_q   <= status_n;
    end
  end

  assign o_lcd_data   = cur_cmd[7:0];
  assign o_lcd_rs     = cur_cmd[8];
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_en     = en_q;
  assign o_lcd_on     = on_q;
  assign o_lcd_status = status_q;

endmodule

// File: tb/tb_lcd_bus_ctrl.sv
// tb/tb_lcd_bus_ctrl.sv - self-checking bench for lcd_bus_ctrl
module tb_lcd_bus_ctrl;

  localparam int T_PWRUP = 50;
  localparam int T_AS    = 2;
  localparam int T_PW    = 4;
  localparam int T_H     = 2;
  localparam int T_EXEC  = 10;
  localparam int T_CLR   = 20;

  logic        clk;
  logic        rst;
  logic [31:0] io;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [31:0] lcd_status;

  lcd_bus_ctrl #(
    .T_PWRUP_CYC (T_PWRUP),
    .T_AS_CYC    (T_AS),
    .T_PW_CYC    (T_PW),
    .T_H_CYC     (T_H),
    .T_EXEC_CYC  (T_EXEC),
    .T_CLR_CYC   (T_CLR)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_io_lcd     (io),
    .o_lcd_data   (lcd_data),
    .o_lcd_rs     (lcd_rs),
    .o_lcd_rw     (lcd_rw),
    .o_lcd_en     (lcd_en),
    .o_lcd_on     (lcd_on),
    .o_lcd_status (lcd_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [43:0] obs_vec = {lcd_en, lcd_rs, lcd_data, lcd_status, lcd_on, lcd_rw};
  logic [43:0] exp_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: a list of scheduled writes. A write whose "cycle 0" is s
  // drives pins from s+1, EN high s+1+T_AS..s+T_AS+T_PW, last busy cycle s+P.
  typedef struct {int s; logic rs; logic [7:0] d;} wr_t;
  wr_t        wq[$];
  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         t;
  int         cur_end;
  bit         pend_v, ovr, req_prev_m, on_m, after_rst;
  logic [8:0] pend_c;

  function automatic int period(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLR : T_EXEC;
    return T_AS + T_PW + T_H + w;
  endfunction

  task automatic model_update();
    bit nr, drop;
    logic [8:0] c;
    int s;
    if (rst) begin
      wq.delete();
      pend_v = 0; ovr = 0; req_prev_m = 0; on_m = 0; after_rst = 1; t = 0;
      s = T_PWRUP;
      for (int k = 0; k < 4; k++) begin
        wq.push_back('{s, 1'b0, rom[k]});
        cur_end = s + period(1'b0, rom[k]);
        s = cur_end + 1;
      end
    end else begin
      nr = (io[30] != req_prev_m);
      req_prev_m = io[30];
      c = {io[9], io[7:0]};
      drop = 0;
      if (t == cur_end && pend_v) begin
        wq.push_back('{t, pend_c[8], pend_c[7:0]});
        cur_end = t + period(pend_c[8], pend_c[7:0]);
        pend_v = 0;
      end
      if (nr) begin
        if (t > cur_end && !pend_v) begin
          wq.push_back('{t, c[8], c[7:0]});
          cur_end = t + period(c[8], c[7:0]);
        end else if (!pend_v) begin
          pend_v = 1;
          pend_c = c;
        end else begin
          drop = 1;
        end
      end
      ovr = io[31] ? (ovr | drop) : 1'b0;
      on_m = io[31];
      after_rst = 0;
      t++;
    end
  endtask

  task automatic compute_exp();
    logic en, rs, busy;
    logic [7:0] d;
    if (after_rst) begin
      exp_vec = '0;
    end else begin
      en = 0; rs = 0; d = '0;
      foreach (wq[i]) begin
        if (t >= wq[i].s + 1 + T_AS && t <= wq[i].s + T_AS + T_PW) en = 1;
        if (t >= wq[i].s + 1) begin
          rs = wq[i].rs;
          d  = wq[i].d;
        end
      end
      busy = (t <= cur_end) || pend_v;
      exp_vec = {en, rs, d, 30'b0, ovr, busy, on_m, 1'b0};
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io  = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec !== 44'h0) begin
        errors++;
        $display("FAIL reset_outputs got %h want %h", obs_vec, 44'h0);
      end
    end
  endtask

  task automatic test_init();
    logic [7:0] seen[$];
    logic prev_en;
    rst = 1'b0;
    io  = 32'h8000_0000;
    prev_en = 1'b0;
    for (int i = 0; i < 145; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL init_cycle t=%0d got %h want %h", t, obs_vec, exp_vec);
      end
      if (lcd_en === 1'b1 && prev_en !== 1'b1) seen.push_back(lcd_data);
      prev_en = lcd_en;
    end
    checks++;
    if (seen.size() != 4) begin
      errors++;
      $display("FAIL init_pulse_count got %0d want 4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (seen[k] !== rom[k]) begin
          errors++;
          $display("FAIL init_data[%0d] got %h want %h", k, seen[k], rom[k]);
        end
      end
    end
    checks++;
    if (lcd_status !== 32'h0) begin
      errors++;
      $display("FAIL init_done_status got %h want 0", lcd_status);
    end
  endtask

  task automatic test_single();
    int first_en, n_en, idle_at;
    first_en = -1; n_en = 0; idle_at = -1;
    io[9] = 1'b1; io[7:0] = 8'h41; io[30] = ~io[30];
    for (int k = 1; k <= 25; k++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_cycle k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      if (lcd_en === 1'b1) begin
        if (first_en < 0) first_en = k;
        n_en++;
      end
      if (idle_at < 0 && lcd_status[0] === 1'b0) idle_at = k;
    end
    checks++;
    if (first_en != T_AS + 1) begin
      errors++;
      $display("FAIL single_en_start got %0d want %0d", first_en, T_AS + 1);
    end
    checks++;
    if (n_en != T_PW) begin
      errors++;
      $display("FAIL single_en_width got %0d want %0d", n_en, T_PW);
    end
    checks++;
    if (idle_at != T_AS + T_PW + T_H + T_EXEC + 1) begin
      errors++;
      $display("FAIL single_idle_at got %0d want %0d", idle_at, T_AS + T_PW + T_H + T_EXEC + 1);
    end
  endtask

  task automatic test_capture();
    io[9] = 1'b1; io[7:0] = 8'h5A; io[30] = ~io[30];
    for (int k = 1; k <= 23; k++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL capture_cycle k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      if (k == 5) begin
        checks++;
        if ({lcd_rs, lcd_data} !== 9'h15A) begin
          errors++;
          $display("FAIL capture_pins got %h want %h", {lcd_rs, lcd_data}, 9'h15A);
        end
      end
      if (k == 1) begin
        io[9] = 1'b0; io[7:0] = 8'hA5;
      end
    end
  endtask

  task automatic test_wait_len();
    int idle_at, want;
    for (int j = 0; j < 2; j++) begin
      io[9]   = 1'b0;
      io[7:0] = (j == 0) ? 8'h02 : 8'h80;
      want    = T_AS + T_PW + T_H + ((j == 0) ? T_CLR : T_EXEC) + 1;
      io[30]  = ~io[30];
      idle_at = -1;
      for (int k = 1; k <= 35; k++) begin
        tick();
        checks++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL wait_len_cycle j=%0d k=%0d got %h want %h", j, k, obs_vec, exp_vec);
        end
        if (idle_at < 0 && lcd_status[0] === 1'b0) idle_at = k;
      end
      checks++;
      if (idle_at != want) begin
        errors++;
        $display("FAIL wait_len cmd=%h got %0d want %0d", io[7:0], idle_at, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen[$];
    logic prev_en;
    prev_en = 1'b0;
    io[9] = 1'b1; io[7:0] = 8'h31; io[30] = ~io[30];
    for (int k = 1; k <= 45; k++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL b2b_cycle k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      if (lcd_en === 1'b1 && prev_en !== 1'b1) seen.push_back(lcd_data);
      prev_en = lcd_en;
      if (k == 8) begin
        checks++;
        if (lcd_status !== 32'h3) begin
          errors++;
          $display("FAIL b2b_overrun_status got %h want 3", lcd_status);
        end
      end
      if (k == 40) begin
        checks++;
        if (lcd_status !== 32'h2) begin
          errors++;
          $display("FAIL b2b_sticky_overrun got %h want 2", lcd_status);
        end
      end
      if (k == 41) begin
        checks++;
        if (lcd_status !== 32'h0) begin
          errors++;
          $display("FAIL b2b_on_clears_overrun got %h want 0", lcd_status);
        end
      end
      if (k == 3)  begin io[7:0] = 8'h32; io[30] = ~io[30]; end
      if (k == 5)  begin io[7:0] = 8'h33; io[30] = ~io[30]; end
      if (k == 40) io[31] = 1'b0;
      if (k == 41) io[31] = 1'b1;
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 8'h31 || seen[1] !== 8'h32) begin
      errors++;
      $display("FAIL b2b_sequence got n=%0d first=%h want n=2 31,32",
               seen.size(), (seen.size() > 0) ? seen[0] : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] seen[$];
    logic prev_en;
    io[9] = 1'b1; io[7:0] = 8'h55; io[30] = ~io[30];
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_pre k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
    end
    checks++;
    if (lcd_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_pulse got %b want 1", lcd_en);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (obs_vec !== 44'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %h want 0", obs_vec);
    end
    rst = 1'b0;
    prev_en = 1'b0;
    for (int i = 0; i < 145; i++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL rst_mid_reinit t=%0d got %h want %h", t, obs_vec, exp_vec);
      end
      if (lcd_en === 1'b1 && prev_en !== 1'b1) seen.push_back(lcd_data);
      prev_en = lcd_en;
    end
    checks++;
    if (seen.size() < 4 || seen[0] !== 8'h38 || seen[1] !== 8'h0C ||
        seen[2] !== 8'h01 || seen[3] !== 8'h06) begin
      errors++;
      $display("FAIL rst_mid_init_seq got n=%0d want 38,0C,01,06", seen.size());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      tick();
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_cycle k=%0d got %h want %h", k, obs_vec, exp_vec);
      end
      io[29:0] = {io[30] ? 1'b1 : 1'b0, 29'($urandom)};
      io[29]   = 1'($urandom);
      io[31]   = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        io[9] = 1'b0;
        io[7:0] = 8'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 9) == 0) begin
        if (!io[9] && io[7:0] == 8'h00) io[7:0] = 8'h01;
        io[30] = ~io[30];
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    io  = '0;
    test_reset();
    test_init();
    test_single();
    test_capture();
    test_wait_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
